// File: rtl/booth_mult_sequencer.sv
// booth_mult_sequencer
//   Radix-2 Booth control FSM for a sequential signed multiplier datapath.
//   Sequences LOAD, then WIDTH iterations of EVAL/SHIFT, then a one-cycle DONE.
//   Strobes decode combinationally from the state register and Q[0]/Q[-1].
//   Optional feature macro: BOOTH_SKIP_EN
//     When it is defined, EVAL shifts directly when no add/subtract is needed,
//     so those iterations skip the SHIFT state.
//   Reset is synchronous and active-high.

module booth_mult_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             q_lsb,
  input  logic             q_prev,
  output logic             load_en,
  output logic             alu_en,
  output logic             alu_sub,
  output logic             shift_en,
  output logic             shift_mode,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;

  // Booth pair decode: 10 -> subtract, 01 -> add, 00/11 -> no ALU write.
  logic need_op;
  logic last_iter;

  assign need_op   = q_lsb ^ q_prev;
  assign last_iter = (iter == CNT_W'(1));

  // The chain always shifts arithmetically so the partial product keeps its sign.
  assign shift_mode = 1'b0;

  // State and iteration counter; reset aborts any operation without a done.
  // NOTE: every register here is written with <= so all updates in this block
  // see the values from before the clock edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      iter  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= LOAD;
        end
        LOAD: begin
          iter  <= CNT_W'(WIDTH);
          state <= EVAL;
        end
        EVAL: begin
`ifdef BOOTH_SKIP_EN
          if (!need_op) begin
            iter  <= iter - CNT_W'(1);
            state <= last_iter ? DONE : EVAL;
          end else begin
            state <= SHIFT;
          end
`else
          state <= SHIFT;
`endif
        end
        SHIFT: begin
          iter  <= iter - CNT_W'(1);
          state <= last_iter ? DONE : EVAL;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          iter  <= '0;
        end
      endcase
    end
  end

  // Strobe decode from the current state and the datapath status bits.
  // NOTE: every output gets a default before the case so that no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    load_en  = 1'b0;
    alu_en   = 1'b0;
    alu_sub  = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      LOAD: begin
        busy    = 1'b1;
        load_en = 1'b1;
      end
      EVAL: begin
        busy    = 1'b1;
        alu_en  = need_op;
        alu_sub = q_lsb & ~q_prev;
`ifdef BOOTH_SKIP_EN
        shift_en = ~need_op;
`endif
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// tb_booth_mult_sequencer
//   Directed bench for booth_mult_sequencer at WIDTH=4. A small {A,Q,Q-1}
//   datapath is modelled here and driven by the sequencer strobes, so the
//   products can be compared with hand-computed values.
//   Build with +define+BOOTH_SKIP_EN to exercise the skip variant.

module tb_booth_mult_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef BOOTH_SKIP_EN
  localparam int LAT_Q0 = 6;   // Q=0000: no ALU ops
  localparam int LAT_Q3 = 8;   // Q=0011: two ALU ops
`else
  localparam int LAT_Q0 = 10;
  localparam int LAT_Q3 = 10;
`endif
  localparam int LAT_Q5 = 10;  // Q=0101: four ALU ops, same in both builds

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             q_lsb;
  logic             q_prev;
  logic             load_en;
  logic             alu_en;
  logic             alu_sub;
  logic             shift_en;
  logic             shift_mode;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter;

  // Operands presented to the modelled datapath.
  logic [3:0] mcand = '0;
  logic [3:0] mult  = '0;

  // Modelled datapath state.
  logic [3:0] acc  = '0;
  logic [3:0] qr   = '0;
  logic       qm1  = 1'b0;
  logic [3:0] mreg = '0;

  int checks = 0;
  int errors = 0;

  logic [6:0] outs;
  assign outs = {load_en, alu_en, alu_sub, shift_en, shift_mode, busy, done};

  assign q_lsb  = qr[0];
  assign q_prev = qm1;

  booth_mult_sequencer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .q_lsb     (q_lsb),
    .q_prev    (q_prev),
    .load_en   (load_en),
    .alu_en    (alu_en),
    .alu_sub   (alu_sub),
    .shift_en  (shift_en),
    .shift_mode(shift_mode),
    .busy      (busy),
    .done      (done),
    .iter      (iter)
  );

  always #5 clk = ~clk;

  // Datapath reacting to the sequencer strobes.
  always @(posedge clk) begin
    if (load_en) begin
      acc  <= '0;
      qr   <= mult;
      qm1  <= 1'b0;
      mreg <= mcand;
    end else if (alu_en) begin
      acc <= alu_sub ? acc - mreg : acc + mreg;
    end else if (shift_en) begin
      {acc, qr, qm1} <= {acc[3], acc, qr};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Properties that must hold every cycle outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      check("alu_shift_excl", {31'b0, alu_en & shift_en}, 32'd0);
      check("shift_mode_zero", {31'b0, shift_mode}, 32'd0);
    end
  end

  // One multiply from IDLE; cycle 1 is LOAD. Returns observed timing and result.
  task automatic run_op(input logic [3:0] m, input logic [3:0] q,
                        output int done_cyc, output int n_alu, output int n_shift,
                        output logic [7:0] ops_seq, output logic [7:0] prod,
                        output logic busy_after, output logic [CNT_W-1:0] iter2,
                        output logic [CNT_W-1:0] iter_done);
    done_cyc = 0;
    n_alu    = 0;
    n_shift  = 0;
    ops_seq  = '0;
    prod     = '0;
    iter2    = '1;
    iter_done = '1;
    @(negedge clk);
    mcand = m;
    mult  = q;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 2) iter2 = iter;
      if (alu_en) n_alu++;
      if (shift_en) n_shift++;
      if (busy && !load_en && !shift_en && !done)
        ops_seq = {ops_seq[5:0], alu_en & alu_sub, alu_en & ~alu_sub};
      if (done) begin
        done_cyc  = c;
        prod      = {acc, qr};
        iter_done = iter;
        break;
      end
    end
    @(negedge clk);
    busy_after = busy;
  endtask

  int               dc, na, ns;
  logic [7:0]       seq, prod;
  logic             bafter;
  logic [CNT_W-1:0] it2, itd;
  int               loads[$];
  int               dones[$];
  int               late_dones;

  initial begin
    // 1. reset with start held high: everything stays at 0.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("rst1_outs", {25'b0, outs}, 32'd0);
    check("rst1_iter", {29'b0, iter}, 32'd0);
    @(negedge clk);
    check("rst2_outs", {25'b0, outs}, 32'd0);
    check("rst2_iter", {29'b0, iter}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_outs", {25'b0, outs}, 32'd0);

    // 2. zero multiplier: no ALU writes, four shifts.
    run_op(4'd5, 4'b0000, dc, na, ns, seq, prod, bafter, it2, itd);
    check("q0_done_cyc", dc, LAT_Q0);
    check("q0_alu_cnt", na, 0);
    check("q0_shift_cnt", ns, 4);
    check("q0_prod", {24'b0, prod}, 32'h00);
    check("q0_busy_after", {31'b0, bafter}, 32'd0);
    check("q0_iter_c2", {29'b0, it2}, 32'd4);
    check("q0_iter_done", {29'b0, itd}, 32'd0);

    // 3. 3 x 3 and -3 x 3.
    run_op(4'd3, 4'b0011, dc, na, ns, seq, prod, bafter, it2, itd);
    check("p9_done_cyc", dc, LAT_Q3);
    check("p9_alu_cnt", na, 2);
    check("p9_shift_cnt", ns, 4);
    check("p9_prod", {24'b0, prod}, 32'h09);
    check("p9_busy_after", {31'b0, bafter}, 32'd0);
`ifndef BOOTH_SKIP_EN
    // EVAL ops in order: sub, none, add, none.
    check("p9_op_seq", {24'b0, seq}, 32'b10_00_01_00);
`endif
    run_op(4'b1101, 4'b0011, dc, na, ns, seq, prod, bafter, it2, itd);
    check("n9_done_cyc", dc, LAT_Q3);
    check("n9_prod", {24'b0, prod}, 32'hF7);

    // 4. start held through a run, then stray start pulses while busy.
    @(negedge clk);
    mcand = 4'd0;
    mult  = 4'd0;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 2 * LAT_Q0 + 5; c++) begin
      @(negedge clk);
      if (load_en) loads.push_back(c);
      if (done) dones.push_back(c);
      start = (c <= LAT_Q0 + 1) || (c == LAT_Q0 + 4) || (c == LAT_Q0 + 5);
    end
    check("hold_load_cnt", loads.size(), 2);
    check("hold_load0", loads.size() > 0 ? loads[0] : -1, 1);
    check("hold_load1", loads.size() > 1 ? loads[1] : -1, LAT_Q0 + 2);
    check("hold_done_cnt", dones.size(), 2);
    check("hold_done0", dones.size() > 0 ? dones[0] : -1, LAT_Q0);
    check("hold_done1", dones.size() > 1 ? dones[1] : -1, 2 * LAT_Q0 + 1);
    check("hold_idle_end", {31'b0, busy}, 32'd0);

    // 5. reset in the second SHIFT, then a fresh multiply.
    @(negedge clk);
    mcand = 4'd3;
    mult  = 4'b0101;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) begin
        check("abort_in_shift", {31'b0, shift_en}, 32'd1);
        reset = 1'b1;
      end
    end
    @(negedge clk);
    check("abort_outs", {25'b0, outs}, 32'd0);
    check("abort_iter", {29'b0, iter}, 32'd0);
    reset = 1'b0;
    late_dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) late_dones++;
    end
    check("abort_quiet", late_dones, 0);
    run_op(4'd3, 4'b0101, dc, na, ns, seq, prod, bafter, it2, itd);
    check("fresh_done_cyc", dc, LAT_Q5);
    check("fresh_alu_cnt", na, 4);
    check("fresh_prod", {24'b0, prod}, 32'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
